// File: rtl/serial_subtractor_nbit.sv
// Bit-serial subtractor: diff = a - b computed LSB first through one full-adder cell (a + ~b + 1).
// Optional signed-overflow output is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor_nbit #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, a_sr_nxt;
    logic [WIDTH-1:0] b_sr, b_sr_nxt;
    logic [WIDTH-2:0] res_sr, res_sr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             carry, carry_nxt;
    logic             busy_nxt, done_nxt, borrow_nxt;
    logic [WIDTH-1:0] diff_nxt;
    logic             sum_c, cout_c, nb_c;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb, a_msb_nxt, b_msb, b_msb_nxt, ovf_nxt;
`endif

    // Single full-adder cell fed with the inverted subtrahend bit
    assign nb_c   = ~b_sr[0];
    assign sum_c  = a_sr[0] ^ nb_c ^ carry;
    assign cout_c = (a_sr[0] & nb_c) | (a_sr[0] & carry) | (nb_c & carry);

    always_comb begin
        state_nxt  = state;
        a_sr_nxt   = a_sr;
        b_sr_nxt   = b_sr;
        res_sr_nxt = res_sr;
        cnt_nxt    = cnt;
        carry_nxt  = carry;
        done_nxt   = 1'b0;
        diff_nxt   = diff;
        borrow_nxt = borrow;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_nxt  = a_msb;
        b_msb_nxt  = b_msb;
        ovf_nxt    = ovf;
`endif
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    state_nxt = RUN;
                    a_sr_nxt  = a;
                    b_sr_nxt  = b;
                    carry_nxt = 1'b1;
                    cnt_nxt   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_nxt = a[WIDTH-1];
                    b_msb_nxt = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_sr_nxt   = a_sr >> 1;
                b_sr_nxt   = b_sr >> 1;
                res_sr_nxt = (WIDTH-1)'({sum_c, res_sr} >> 1);
                carry_nxt  = cout_c;
                cnt_nxt    = cnt + CNT_W'(1);
                // Final bit: publish the full result so it is valid during the done cycle
                if (cnt == LAST_BIT) begin
                    state_nxt  = DONE;
                    done_nxt   = 1'b1;
                    diff_nxt   = {sum_c, res_sr};
                    borrow_nxt = ~cout_c;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_nxt    = (a_msb != b_msb) && (sum_c != a_msb);
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            a_sr   <= a_sr_nxt;
            b_sr   <= b_sr_nxt;
            res_sr <= res_sr_nxt;
            cnt    <= cnt_nxt;
            carry  <= carry_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            diff   <= diff_nxt;
            borrow <= borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= a_msb_nxt;
            b_msb  <= b_msb_nxt;
            ovf    <= ovf_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Testbench for serial_subtractor_nbit (WIDTH=3): vector table, handshake corner cases,
// exhaustive sweep and random operations against an arithmetic reference.
module tb_serial_subtractor_nbit;

    localparam int unsigned WIDTH = 3;
    localparam int MASK = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a, b, diff;
    logic             busy, done, borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int held_diff;
    int held_borrow;

    typedef struct {
        int a;
        int b;
        int exp_diff;
        int exp_borrow;
    } vec_t;

    serial_subtractor_nbit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int ref_diff(input int x, input int y);
        return (x - y) & MASK;
    endfunction

    function automatic int ref_borrow(input int x, input int y);
        return (x < y) ? 1 : 0;
    endfunction

    // Signed overflow: true difference of the two's-complement values leaves the WIDTH-bit range
    function automatic int ref_ovf(input int x, input int y);
        int sx, sy, r;
        sx = (x >= (1 << (WIDTH - 1))) ? x - (1 << WIDTH) : x;
        sy = (y >= (1 << (WIDTH - 1))) ? y - (1 << WIDTH) : y;
        r  = sx - sy;
        return ((r < -(1 << (WIDTH - 1))) || (r >= (1 << (WIDTH - 1)))) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the accepting edge; waits (bounded) for done and checks the result
    task automatic wait_done(input int ed, input int eb, input int eo);
        int lat = 0;
        bit seen = 0;
        for (int i = 0; i < 3 * WIDTH && !seen; i++) begin
            check("diff_held", diff, held_diff);
            check("borrow_held", borrow, held_borrow);
            tick();
            lat++;
            seen = done;
        end
        check("done_seen", seen, 1);
        if (seen) begin
            check("latency", lat, WIDTH);
            check("busy_at_done", busy, 0);
            check("diff", diff, ed);
            check("borrow", borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
            check("ovf", ovf, eo);
`else
            if (eo < 0) $display("unexpected ovf arg");
`endif
            held_diff   = ed;
            held_borrow = eb;
            tick();
            check("done_pulse_width", done, 0);
        end
    endtask

    task automatic run_op(input int x, input int y, input int ed, input int eb);
        a     = WIDTH'(x);
        b     = WIDTH'(y);
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = WIDTH'($urandom_range(0, MASK));
        b     = WIDTH'($urandom_range(0, MASK));
        check("busy_after_start", busy, 1);
        wait_done(ed, eb, ref_ovf(x, y));
    endtask

    initial begin
        vec_t vecs[7];
        bit   seen;
        int   x, y;

        vecs[0] = '{7, 2, 5, 0};
        vecs[1] = '{6, 7, 7, 1};
        vecs[2] = '{0, 0, 0, 0};
        vecs[3] = '{3, 5, 6, 1};
        vecs[4] = '{4, 1, 3, 0};
        vecs[5] = '{0, 7, 1, 1};
        vecs[6] = '{7, 7, 0, 0};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        held_diff = 0;
        held_borrow = 0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow);

        // start held through RUN with new operands: ignored until the done cycle, then accepted
        a = 3'd7;
        b = 3'd2;
        start = 1'b1;
        tick();
        a = 3'd1;
        b = 3'd3;
        check("busy_held_start", busy, 1);
        wait_done(5, 0, ref_ovf(7, 2));
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done(ref_diff(1, 3), ref_borrow(1, 3), ref_ovf(1, 3));

        // Reset two cycles into an operation aborts it
        a = 3'd5;
        b = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        check("abort_done", done, 0);
        held_diff = 0;
        held_borrow = 0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            tick();
            if (done) seen = 1;
        end
        check("abort_no_done", seen, 0);
        check("abort_diff_after", diff, 0);

`ifdef SERIAL_SUB_OVF_EN
        run_op(4, 1, 3, 0);
        check("ovf_neg4_minus1", ovf, 1);
        run_op(2, 1, 1, 0);
        check("ovf_2_minus1", ovf, 0);
`endif

        for (int i = 0; i <= MASK; i++) begin
            for (int j = 0; j <= MASK; j++) begin
                run_op(i, j, ref_diff(i, j), ref_borrow(i, j));
            end
        end

        for (int k = 0; k < 30; k++) begin
            x = $urandom_range(0, MASK);
            y = $urandom_range(0, MASK);
            run_op(x, y, ref_diff(x, y), ref_borrow(x, y));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
